// File: rtl/sub_borrow_pipe.sv
// sub_borrow_pipe: two-stage 8-bit borrow-lookahead subtractor, diff = a - b - bin.
// Stage 1 resolves the low nibble and the mid borrow; stage 2 resolves the high nibble.
// Build macro SUB_BORROW_PIPE_SAT_EN selects unsigned saturating subtract (underflow -> 8'h00).
module sub_borrow_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] diff,
  output logic       bout,
  output logic       out_valid,
  input  logic       out_ready
);

  // Stage 1 registers
  logic       s1_valid;
  logic [3:0] s1_dlo;
  logic       s1_bmid;
  logic [3:0] s1_ahi;
  logic [3:0] s1_bhi;

  logic       s1_adv;
  logic       s2_adv;

  // Low nibble terms; lo_br[i] is the borrow into bit i, lo_br[4] = br[3]
  logic [3:0] lo_g;
  logic [3:0] lo_p;
  logic [3:0] lo_d;
  logic [4:0] lo_br;

  // High nibble terms; hi_br[0] = br[3], hi_br[4] = br[7]
  logic [3:0] hi_g;
  logic [3:0] hi_p;
  logic [3:0] hi_d;
  logic [4:0] hi_br;

  logic [7:0] diff_nxt;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & rst_n;

  // Borrow lookahead over bits 3:0 of the live operands
  always_comb begin
    lo_br[0] = bin;
    for (int i = 0; i < 4; i++) begin
      lo_g[i]     = ~a[i] & b[i];
      lo_p[i]     = ~(a[i] ^ b[i]);
      lo_d[i]     = a[i] ^ b[i] ^ lo_br[i];
      lo_br[i+1]  = lo_g[i] | (lo_p[i] & lo_br[i]);
    end
  end

  // Stage 1 capture: load on advance, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dlo   <= 4'h0;
      s1_bmid  <= 1'b0;
      s1_ahi   <= 4'h0;
      s1_bhi   <= 4'h0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_dlo   <= lo_d;
      s1_bmid  <= lo_br[4];
      s1_ahi   <= a[7:4];
      s1_bhi   <= b[7:4];
    end
  end

  // Borrow lookahead over bits 7:4 from the stage 1 registers
  always_comb begin
    hi_br[0] = s1_bmid;
    for (int i = 0; i < 4; i++) begin
      hi_g[i]     = ~s1_ahi[i] & s1_bhi[i];
      hi_p[i]     = ~(s1_ahi[i] ^ s1_bhi[i]);
      hi_d[i]     = s1_ahi[i] ^ s1_bhi[i] ^ hi_br[i];
      hi_br[i+1]  = hi_g[i] | (hi_p[i] & hi_br[i]);
    end
    diff_nxt = {hi_d, s1_dlo};
`ifdef SUB_BORROW_PIPE_SAT_EN
    if (hi_br[4]) begin
      diff_nxt = 8'h00;
    end
`endif
  end

  // Stage 2 capture: output registers hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= 8'h00;
      bout      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      diff      <= diff_nxt;
      bout      <= hi_br[4];
    end
  end

endmodule

// File: tb/tb_sub_borrow_pipe.sv
// tb_sub_borrow_pipe: scoreboard bench for sub_borrow_pipe with an arithmetic reference model.
module tb_sub_borrow_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] diff;
  logic       bout;
  logic       out_valid;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] sb[$];

  sub_borrow_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // {bout, diff} from plain integer subtraction
  function automatic logic [8:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic c);
    int r;
    logic [8:0] res;
    r = int'(x) - int'(y) - int'(c);
    res[8] = (r < 0);
    res[7:0] = r[7:0];
`ifdef SUB_BORROW_PIPE_SAT_EN
    if (res[8]) res[7:0] = 8'h00;
`endif
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; record accepted operands.
  task automatic step(input logic rst, input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic c, input logic ordy, output logic fired);
    @(negedge clk);
    rst_n = rst;
    in_valid = v;
    a = x;
    b = y;
    bin = c;
    out_ready = ordy;
    #1;
    fired = in_valid && in_ready;
    if (fired) sb.push_back(ref_model(a, b, bin));
  endtask

  task automatic idle(input logic ordy);
    logic f;
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ordy, f);
  endtask

  // Single transfer then check exact two-edge latency against a fixed expectation.
  task automatic directed(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic [8:0] expv);
    logic f;
    step(1'b1, 1'b1, x, y, c, 1'b1, f);
    check({name, "_accept"}, f, 1);
    idle(1'b1);
    check({name, "_lat1_valid"}, out_valid, 0);
    idle(1'b1);
    check({name, "_lat2_valid"}, out_valid, 1);
    check({name, "_value"}, {bout, diff}, expv);
  endtask

  // Monitor: pop and compare on every output transfer
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", {bout, diff});
        end else begin
          e = sb.pop_front();
          check("scoreboard_result", {bout, diff}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    logic [7:0] bp_a[4];
    logic [7:0] bp_b[4];
    logic       bp_c[4];
    logic [8:0] exp0;
    int idx;
    int cyc;

    // Reset behaviour
    step(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, f);
    check("in_ready_in_reset", in_ready, 0);
    step(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, f);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", {bout, diff}, 0);
    check("in_ready_in_reset2", in_ready, 0);
    idle(1'b1);
    check("in_ready_after_reset", in_ready, 1);

    // Directed vectors
    directed("basic", 8'h5A, 8'h3C, 1'b0, 9'h01E);
`ifdef SUB_BORROW_PIPE_SAT_EN
    directed("underflow", 8'h10, 8'h20, 1'b0, 9'h100);
    directed("ripple00", 8'h00, 8'h00, 1'b1, 9'h100);
    directed("rippleff", 8'hFF, 8'hFF, 1'b1, 9'h100);
`else
    directed("underflow", 8'h10, 8'h20, 1'b0, 9'h1F0);
    directed("ripple00", 8'h00, 8'h00, 1'b1, 9'h1FF);
    directed("rippleff", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
`endif
    directed("ripple80", 8'h80, 8'h01, 1'b0, 9'h07F);

    // Back-pressure: four pairs, out_ready low for cycles 2..4
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
      bp_c[i] = 1'($urandom);
    end
    exp0 = ref_model(bp_a[0], bp_b[0], bp_c[0]);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      step(1'b1, 1'b1, bp_a[idx], bp_b[idx], bp_c[idx], !(cyc >= 2 && cyc < 5), f);
      if (f) idx++;
      if (cyc >= 2 && cyc < 5) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        check("bp_output_stable", {bout, diff}, exp0);
        check("bp_accepted_two", idx, 2);
      end
      cyc++;
    end
    check("bp_all_accepted", idx, 4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bp_drained", sb.size(), 0);

    // Reset mid-flight
    step(1'b1, 1'b1, 8'h33, 8'h11, 1'b0, 1'b1, f);
    step(1'b1, 1'b1, 8'h44, 8'h22, 1'b1, 1'b1, f);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, f);
    sb.delete();
    idle(1'b1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", {bout, diff}, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, f);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check("final_drain_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
